// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, optional parity, 1..2 stop bits)
// with break-safe idle recovery. dbg_state encoding: 0 IDLE, 1 START, 2 DATA, 3 PAR, 4 STOP, 5 WAIT_HI.
`timescale 1ns/1ps
module uart_rx_cfg #(
  parameter int BAUD_DIV  = 2604,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX,
  input  logic              clr_rdy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rdy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_W - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PAR     = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_bit_cnt;
  logic              r_stop_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_bit;
  logic              r_ferr_acc;

  logic w_rx;
  logic w_tick;
  logic w_par_xor;
  logic w_par_err;
  logic w_frame_err;

  assign w_rx        = r_sync2;
  assign w_tick      = (r_cnt == '0);
  assign w_par_xor   = (^r_shift) ^ r_par_bit;
  assign w_par_err   = (PARITY == 1) ? w_par_xor :
                       (PARITY == 2) ? ~w_par_xor : 1'b0;
  assign w_frame_err = r_ferr_acc | ~w_rx;
  assign dbg_state   = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX;
      r_sync2 <= r_sync1;
    end
  end

  // Handshake: rdy rises when a frame completes and holds until clr_rdy is seen
  // on a clock edge; a completion on that same edge wins and keeps rdy set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_ferr_acc <= 1'b0;
      rx_data    <= '0;
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clr_rdy) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      if (!w_tick) begin
        r_cnt <= r_cnt - 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (!w_rx) begin
            r_state <= START;
            r_cnt   <= HALF_CNT;
          end
        end
        START: begin
          if (w_tick) begin
            if (w_rx) begin
              r_state <= IDLE;
            end else begin
              r_state   <= DATA;
              r_cnt     <= FULL_CNT;
              r_bit_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift   <= {w_rx, r_shift[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_cnt     <= FULL_CNT;
            if (r_bit_cnt == LAST_DATA) begin
              r_state    <= (PARITY != 0) ? PAR : STOP;
              r_stop_cnt <= 1'b0;
              r_ferr_acc <= 1'b0;
            end
          end
        end
        PAR: begin
          if (w_tick) begin
            r_par_bit <= w_rx;
            r_cnt     <= FULL_CNT;
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_cnt      <= FULL_CNT;
            r_ferr_acc <= w_frame_err;
            r_stop_cnt <= r_stop_cnt + 1'b1;
            if (r_stop_cnt == LAST_STOP) begin
              rx_data    <= r_shift;
              parity_err <= w_par_err;
              frame_err  <= w_frame_err;
              rdy        <= 1'b1;
              overrun    <= overrun | rdy;
              r_cnt      <= '0;
              // A low final stop sample may be a break: hold off until the line idles high.
              r_state    <= w_rx ? IDLE : WAIT_HI;
            end
          end
        end
        WAIT_HI: begin
          if (w_rx) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and an 8E1 instance, both at 16 clocks per bit,
// checked every cycle against a frame-level reference model plus literal spot checks.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int B = 16;
  localparam int H = B / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_n, clr_n, rx_p, clr_p;
  logic [7:0] data_n, data_p;
  logic       rdy_n, perr_n, ferr_n, ovr_n;
  logic       rdy_p, perr_p, ferr_p, ovr_p;
  logic [2:0] st_n, st_p;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    longint     t_fall;
  } exp_t;

  exp_t       exp_q0[$];
  exp_t       exp_q1[$];
  logic [7:0] m_data [2];
  logic       m_rdy  [2];
  logic       m_ovr  [2];
  logic       m_perr [2];
  logic       m_ferr [2];

  uart_rx_cfg #(.BAUD_DIV(B), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst(rst), .RX(rx_n), .clr_rdy(clr_n),
    .rx_data(data_n), .rdy(rdy_n), .parity_err(perr_n), .frame_err(ferr_n),
    .overrun(ovr_n), .dbg_state(st_n)
  );

  uart_rx_cfg #(.BAUD_DIV(B), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst(rst), .RX(rx_p), .clr_rdy(clr_p),
    .rx_data(data_p), .rdy(rdy_p), .parity_err(perr_p), .frame_err(ferr_p),
    .overrun(ovr_p), .dbg_state(st_p)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got %0d checks, expected the run to finish", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic int lat_of(input int ch);
    return 3 + H + (8 + ch + 1) * B;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int ch, input logic v);
    if (ch == 0) rx_n = v;
    else         rx_p = v;
  endtask

  task automatic push_exp(input int ch, input exp_t e);
    if (ch == 0) exp_q0.push_back(e);
    else         exp_q1.push_back(e);
  endtask

  task automatic pulse_clr(input int ch);
    if (ch == 0) clr_n = 1'b1; else clr_p = 1'b1;
    wait_clks(1);
    clr_n = 1'b0;
    clr_p = 1'b0;
    wait_clks(1);
  endtask

  // One frame: start, 8 data LSB first, even parity bit on channel 1, one stop bit.
  task automatic send_frame(input int ch, input logic [7:0] d, input logic pbit, input logic stopv);
    exp_t e;
    set_rx(ch, 1'b0);
    e.data   = d;
    e.perr   = (ch == 1) ? ((^d) ^ pbit) : 1'b0;
    e.ferr   = ~stopv;
    e.t_fall = $time;
    push_exp(ch, e);
    wait_clks(B);
    for (int i = 0; i < 8; i++) begin
      set_rx(ch, d[i]);
      wait_clks(B);
    end
    if (ch == 1) begin
      set_rx(ch, pbit);
      wait_clks(B);
    end
    set_rx(ch, stopv);
    wait_clks(B);
    set_rx(ch, 1'b1);
    wait_clks(2);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [11:0] act;
    logic [11:0] cur;
    logic [11:0] nxt;
    exp_t        hd;
    bit          have;
    bit          done;
    longint      t_nom;
    for (int ch = 0; ch < 2; ch++) begin
      act = (ch == 0) ? {data_n, rdy_n, perr_n, ferr_n, ovr_n}
                      : {data_p, rdy_p, perr_p, ferr_p, ovr_p};
      if (rst) begin
        m_data[ch] = 8'h00;
        m_rdy[ch]  = 1'b0;
        m_ovr[ch]  = 1'b0;
        m_perr[ch] = 1'b0;
        m_ferr[ch] = 1'b0;
        if (ch == 0) exp_q0.delete(); else exp_q1.delete();
        chk($sformatf("reset_ch%0d", ch), {20'h0, act}, 32'h0);
      end else begin
        have = (ch == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        done = 1'b0;
        cur  = {m_data[ch], m_rdy[ch], m_perr[ch], m_ferr[ch], m_ovr[ch]};
        if (have) begin
          hd    = (ch == 0) ? exp_q0[0] : exp_q1[0];
          t_nom = hd.t_fall + 10 * lat_of(ch) + 14;
          nxt   = {hd.data, 1'b1, hd.perr, hd.ferr, m_ovr[ch] | m_rdy[ch]};
          if ($time >= t_nom - 10 && (act === nxt || $time >= t_nom + 10)) begin
            chk($sformatf("frame_ch%0d", ch), {20'h0, act}, {20'h0, nxt});
            m_data[ch] = hd.data;
            m_rdy[ch]  = 1'b1;
            m_perr[ch] = hd.perr;
            m_ferr[ch] = hd.ferr;
            m_ovr[ch]  = nxt[0];
            if (ch == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            done = 1'b1;
          end
        end
        if (!done) chk($sformatf("steady_ch%0d", ch), {20'h0, act}, {20'h0, cur});
        if ((ch == 0) ? clr_n : clr_p) begin
          m_rdy[ch] = 1'b0;
          m_ovr[ch] = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic [7:0] pd;
    exp_t       e;
    rst = 1'b1; rx_n = 1'b1; rx_p = 1'b1; clr_n = 1'b0; clr_p = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      m_data[ch] = 8'h00; m_rdy[ch] = 1'b0; m_ovr[ch] = 1'b0;
      m_perr[ch] = 1'b0;  m_ferr[ch] = 1'b0;
    end
    wait_clks(4);
    rst = 1'b0;
    wait_clks(3);
    chk("post_reset_rdy", rdy_n, 0);
    chk("post_reset_data", data_n, 0);
    chk("post_reset_state", st_n, 0);

    // 8N1 0xA5
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    chk("a5_data", data_n, 32'hA5);
    chk("a5_flags", {rdy_n, perr_n, ferr_n, ovr_n}, 4'b1000);
    pulse_clr(0);

    // false start: 4 clocks low
    rx_n = 1'b0;
    wait_clks(4);
    chk("false_start_entered", st_n, 3'd1);
    rx_n = 1'b1;
    wait_clks(2 * B);
    chk("false_start_idle", st_n, 3'd0);
    chk("false_start_rdy", rdy_n, 0);

    // even parity: 0x03 has two ones, so parity bit 1 is wrong, 0 is right
    send_frame(1, 8'h03, 1'b1, 1'b1);
    chk("par_bad_data", data_p, 32'h03);
    chk("par_bad_flags", {rdy_p, perr_p}, 2'b11);
    pulse_clr(1);
    send_frame(1, 8'h03, 1'b0, 1'b1);
    chk("par_good_flags", {rdy_p, perr_p}, 2'b10);

    // randomized traffic on both channels
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(0, d, 1'b0, ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1) pulse_clr(0);
      wait_clks($urandom_range(0, 3 * B));
    end
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(1, d, 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 1) == 1) pulse_clr(1);
      wait_clks($urandom_range(0, 3 * B));
    end

    // break: 20 bit periods low
    pulse_clr(0);
    rx_n     = 1'b0;
    e.data   = 8'h00;
    e.perr   = 1'b0;
    e.ferr   = 1'b1;
    e.t_fall = $time;
    push_exp(0, e);
    wait_clks(15 * B);
    chk("break_wait_hi", st_n, 3'd5);
    chk("break_frame", {data_n, rdy_n, ferr_n, ovr_n}, {8'h00, 3'b110});
    wait_clks(5 * B);
    rx_n = 1'b1;
    wait_clks(2 * B);
    chk("break_idle", st_n, 3'd0);
    send_frame(0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);

    // overrun
    pulse_clr(0);
    send_frame(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    chk("ovr_data", data_n, 32'h22);
    chk("ovr_flags", {rdy_n, ovr_n}, 2'b11);
    pulse_clr(0);
    chk("ovr_cleared", {rdy_n, ovr_n}, 2'b00);
    chk("ovr_data_hold", data_n, 32'h22);

    // reset during data bit 3
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    pd   = 8'hC3;
    rx_n = 1'b0;
    wait_clks(B);
    for (int i = 0; i < 3; i++) begin
      rx_n = pd[i];
      wait_clks(B);
    end
    rx_n = pd[3];
    wait_clks(H);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_now_data", data_n, 0);
    chk("rst_now_flags", {rdy_n, perr_n, ferr_n, ovr_n}, 4'b0000);
    chk("rst_now_state", st_n, 3'd0);
    rx_n = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(3 * B);
    chk("rst_no_partial", rdy_n, 0);
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    chk("rst_5a_data", data_n, 32'h5A);
    chk("rst_5a_flags", {rdy_n, perr_n, ferr_n, ovr_n}, 4'b1000);

    wait_clks(10);
    chk("par_dut_idle", st_p, 3'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
